// File: rtl/ramp_dc_gen_pkg.sv
// Shared definitions for the ramp/DC DAC sample generator.
// Mode encodings double as the FSM state encoding so `mode` is a direct copy of the state.
package ramp_dc_gen_pkg;
  localparam int DATA_W = 16;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_DC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = MODE_IDLE,
    RAMP = MODE_RAMP,
    DC   = MODE_DC
  } state_t;
endpackage

// File: rtl/sample_tick_div.sv
// Sample-rate divider: pulses tick on the last cycle of each DIV-cycle period.
// Holds its count while disabled; clr restarts the period from zero.
module sample_tick_div #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/ramp_dc_gen.sv
// Paced DAC sample source: triangle ramp between latched bounds or live DC level,
// presented over valid/ready with overwrite-on-overrun and frame counting.
module ramp_dc_gen #(
  parameter int DATA_W     = ramp_dc_gen_pkg::DATA_W,
  parameter int SAMPLE_DIV = 100,
  parameter int STEP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ramp_enable,
  input  logic              dc_enable,
  input  logic [DATA_W-1:0] set_min,
  input  logic [DATA_W-1:0] set_max,
  input  logic [DATA_W-1:0] dc_input,
  input  logic [DATA_W-1:0] read_length,
  input  logic              dac_ready,
  output logic [DATA_W-1:0] dac_code,
  output logic              dac_valid,
  output logic [1:0]        mode,
  output logic              frame_done,
  output logic              overrun
);
  import ramp_dc_gen_pkg::*;

  localparam logic [DATA_W:0]   STEP_X = (DATA_W + 1)'(STEP);
  localparam logic [DATA_W-1:0] STEP_N = DATA_W'(STEP);

  state_t            state, state_nx;
  logic              entry;
  logic              tick;
  logic              accept;
  logic [DATA_W-1:0] lo, hi, cur, cur_nx, sample;
  logic              down, down_nx;
  logic [DATA_W-1:0] sample_cnt;
  logic [DATA_W:0]   cur_up, lo_up, cnt_inc;

  sample_tick_div #(.DIV(SAMPLE_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ramp_enable)    state_nx = RAMP;
        else if (dc_enable) state_nx = DC;
      end
      RAMP: if (!ramp_enable) state_nx = IDLE;
      DC:   if (!dc_enable || ramp_enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    entry = (state == IDLE) && (state_nx != IDLE);
    mode  = state;
  end

  // One extra bit of headroom so the bound comparisons cannot wrap near 0 or full scale.
  always_comb begin
    cur_up  = {1'b0, cur} + STEP_X;
    lo_up   = {1'b0, lo} + STEP_X;
    cur_nx  = cur;
    down_nx = down;
    if (lo >= hi) begin
      cur_nx = lo;
    end else if (!down) begin
      if (cur_up >= {1'b0, hi}) begin
        cur_nx  = hi;
        down_nx = 1'b1;
      end else begin
        cur_nx = cur_up[DATA_W-1:0];
      end
    end else begin
      if ({1'b0, cur} <= lo_up) begin
        cur_nx  = lo;
        down_nx = 1'b0;
      end else begin
        cur_nx = cur - STEP_N;
      end
    end
    sample = (state == RAMP) ? cur_nx : dc_input;
  end

  assign accept  = dac_valid && dac_ready;
  assign cnt_inc = {1'b0, sample_cnt} + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo         <= '0;
      hi         <= '0;
      cur        <= '0;
      down       <= 1'b0;
      sample_cnt <= '0;
      dac_code   <= '0;
      dac_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (entry) begin
        sample_cnt <= '0;
        overrun    <= 1'b0;
        dac_valid  <= 1'b1;
        if (state_nx == RAMP) begin
          lo       <= set_min;
          hi       <= set_max;
          cur      <= set_min;
          down     <= 1'b0;
          dac_code <= set_min;
        end else begin
          dac_code <= dc_input;
        end
      end else if (state_nx == IDLE) begin
        dac_valid <= 1'b0;
      end else if (tick) begin
        dac_code  <= sample;
        dac_valid <= 1'b1;
        if (dac_valid && !dac_ready) overrun <= 1'b1;
        if (state == RAMP) begin
          cur  <= cur_nx;
          down <= down_nx;
        end
      end else if (accept) begin
        dac_valid <= 1'b0;
      end

      // A handshake completed in the final running cycle still counts toward the frame.
      if (state != IDLE && accept) begin
        if (read_length != '0 && cnt_inc >= {1'b0, read_length}) begin
          sample_cnt <= '0;
          frame_done <= 1'b1;
        end else begin
          sample_cnt <= cnt_inc[DATA_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_ramp_dc_gen.sv
// Bench for ramp_dc_gen: directed scenarios plus random enables/backpressure,
// checked every cycle against a period-table reference model.
module tb_ramp_dc_gen;
  import ramp_dc_gen_pkg::*;

  localparam int DIV = 4;
  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ramp_enable = 1'b0;
  logic        dc_enable = 1'b0;
  logic        dac_ready = 1'b1;
  logic [15:0] set_min = '0, set_max = '0, dc_input = '0, read_length = '0;

  logic [15:0] dac_code, dac_code3;
  logic        dac_valid, dac_valid3, frame_done, frame_done3, overrun, overrun3;
  logic [1:0]  mode, mode3;

  int checks = 0;
  int errors = 0;

  ramp_dc_gen #(.DATA_W(16), .SAMPLE_DIV(DIV), .STEP(1)) dut (
    .clk(clk), .rst(rst), .ramp_enable(ramp_enable), .dc_enable(dc_enable),
    .set_min(set_min), .set_max(set_max), .dc_input(dc_input), .read_length(read_length),
    .dac_ready(dac_ready), .dac_code(dac_code), .dac_valid(dac_valid), .mode(mode),
    .frame_done(frame_done), .overrun(overrun)
  );

  ramp_dc_gen #(.DATA_W(16), .SAMPLE_DIV(DIV), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .ramp_enable(ramp_enable), .dc_enable(dc_enable),
    .set_min(set_min), .set_max(set_max), .dc_input(dc_input), .read_length(read_length),
    .dac_ready(dac_ready), .dac_code(dac_code3), .dac_valid(dac_valid3), .mode(mode3),
    .frame_done(frame_done3), .overrun(overrun3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One full triangle period: up by s until reaching hi, then down by s back to lo.
  function automatic iq_t build_period(input int lo, input int hi, input int s);
    iq_t q;
    if (lo >= hi) begin
      q.push_back(lo);
      return q;
    end
    for (int v = lo; v < hi; v += s) q.push_back(v);
    q.push_back(hi);
    for (int v = hi - s; v > lo; v -= s) q.push_back(v);
    return q;
  endfunction

  int  m_mode, m_code, m_code3, m_k, m_age, m_cnt, nm;
  bit  m_valid, m_ov, m_fd, acc;
  iq_t per1, per3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_code = 0; m_code3 = 0; m_k = 0; m_age = 0; m_cnt = 0;
      m_valid = 0; m_ov = 0; m_fd = 0;
    end else begin
      acc = m_valid && dac_ready;
      nm  = m_mode;
      case (m_mode)
        0: if (ramp_enable) nm = 1; else if (dc_enable) nm = 2;
        1: if (!ramp_enable) nm = 0;
        default: if (!dc_enable || ramp_enable) nm = 0;
      endcase
      m_fd = 0;
      if (m_mode != 0 && acc) begin
        m_cnt++;
        if (read_length != 0 && m_cnt >= int'(read_length)) begin
          m_fd  = 1;
          m_cnt = 0;
        end
      end
      if (m_mode == 0 && nm != 0) begin
        m_k = 0; m_age = 0; m_ov = 0; m_cnt = 0; m_valid = 1;
        if (nm == 1) begin
          per1 = build_period(int'(set_min), int'(set_max), 1);
          per3 = build_period(int'(set_min), int'(set_max), 3);
          m_code = per1[0]; m_code3 = per3[0];
        end else begin
          m_code = int'(dc_input); m_code3 = int'(dc_input);
        end
      end else if (nm == 0) begin
        m_valid = 0;
      end else begin
        m_age++;
        if (m_age % DIV == 0) begin
          if (m_valid && !acc) m_ov = 1;
          m_k++;
          if (nm == 1) begin
            m_code  = per1[m_k % per1.size()];
            m_code3 = per3[m_k % per3.size()];
          end else begin
            m_code = int'(dc_input); m_code3 = int'(dc_input);
          end
          m_valid = 1;
        end else if (acc) begin
          m_valid = 0;
        end
      end
      m_mode = nm;
    end
  end

  always @(negedge clk) begin
    chk("code",   32'(dac_code),    32'(m_code));
    chk("valid",  32'(dac_valid),   32'(m_valid));
    chk("mode",   32'(mode),        32'(m_mode));
    chk("frame",  32'(frame_done),  32'(m_fd));
    chk("ovr",    32'(overrun),     32'(m_ov));
    chk("code3",  32'(dac_code3),   32'(m_code3));
    chk("valid3", 32'(dac_valid3),  32'(m_valid));
    chk("mode3",  32'(mode3),       32'(m_mode));
    chk("frame3", 32'(frame_done3), 32'(m_fd));
    chk("ovr3",   32'(overrun3),    32'(m_ov));
  end

  int sweep1[8] = '{2, 3, 4, 5, 4, 3, 2, 3};
  int sweep3[8] = '{0, 3, 6, 7, 4, 1, 0, 3};
  int pulses;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_code", 32'(dac_code), 32'd0);
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_mode", 32'(mode), 32'(MODE_IDLE));

    // Triangle sweep 2..5 at STEP=1
    set_min = 16'd2; set_max = 16'd5; dac_ready = 1'b1; ramp_enable = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      chk("sweep1", 32'(dac_code), 32'(sweep1[j]));
      if (j < 7) begin repeat (DIV) @(posedge clk); #1; end
    end
    chk("sweep_mode", 32'(mode), 32'(MODE_RAMP));
    chk("sweep_ovr", 32'(overrun), 32'd0);
    @(negedge clk); ramp_enable = 1'b0;
    repeat (2) @(negedge clk);

    // Non-divisible step 0..7 at STEP=3
    set_min = 16'd0; set_max = 16'd7; ramp_enable = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      chk("sweep3", 32'(dac_code3), 32'(sweep3[j]));
      if (j < 7) begin repeat (DIV) @(posedge clk); #1; end
    end
    @(negedge clk); ramp_enable = 1'b0;
    @(negedge clk);
    chk("exit_mode", 32'(mode), 32'(MODE_IDLE));
    chk("exit_valid", 32'(dac_valid), 32'd0);
    chk("hold_code", 32'(dac_code), 32'd7);
    chk("hold_code3", 32'(dac_code3), 32'd3);

    // DC with a live input change
    dc_input = 16'h1234; dc_enable = 1'b1;
    @(posedge clk); #1;
    chk("dc_first", 32'(dac_code), 32'h1234);
    chk("dc_mode", 32'(mode), 32'(MODE_DC));
    @(negedge clk); dc_input = 16'hABCD;
    repeat (DIV) @(posedge clk); #1;
    chk("dc_track", 32'(dac_code), 32'hABCD);
    @(negedge clk); dc_enable = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: ticks land while unconsumed
    set_min = 16'd100; set_max = 16'd200; dac_ready = 1'b0; ramp_enable = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("bp_ovr", 32'(overrun), 32'd1);
    chk("bp_code", 32'(dac_code), 32'd102);
    dac_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_drain", 32'(dac_valid), 32'd0);
    chk("bp_sticky", 32'(overrun), 32'd1);
    ramp_enable = 1'b0;
    @(negedge clk);

    // Frames of 3, then frame counting off
    read_length = 16'd3; ramp_enable = 1'b1;
    @(negedge clk);
    chk("reentry_ovr", 32'(overrun), 32'd0);
    pulses = int'(frame_done);
    repeat (39) begin @(negedge clk); pulses += int'(frame_done); end
    chk("frames3", 32'(pulses), 32'd3);
    read_length = 16'd0; pulses = 0;
    repeat (40) begin @(negedge clk); pulses += int'(frame_done); end
    chk("frames0", 32'(pulses), 32'd0);
    ramp_enable = 1'b0;
    @(negedge clk);

    // Priority and hold on exit
    set_min = 16'h55; set_max = 16'h60; ramp_enable = 1'b1; dc_enable = 1'b1;
    @(negedge clk);
    chk("prio_mode", 32'(mode), 32'(MODE_RAMP));
    ramp_enable = 1'b0; dc_enable = 1'b0;
    @(negedge clk);
    chk("prio_exit", 32'(mode), 32'(MODE_IDLE));
    chk("prio_hold", 32'(dac_code), 32'h55);

    // Asynchronous reset mid-ramp
    set_min = 16'd2; set_max = 16'd5; ramp_enable = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_code", 32'(dac_code), 32'd0);
    chk("arst_valid", 32'(dac_valid), 32'd0);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_ovr", 32'({frame_done, overrun}), 32'd0);
    ramp_enable = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Inverted bounds hold at min
    set_min = 16'd9; set_max = 16'd4; ramp_enable = 1'b1;
    repeat (3 * DIV) begin @(negedge clk); chk("inv_bounds", 32'(dac_code), 32'd9); end
    ramp_enable = 1'b0;
    @(negedge clk);

    // Full-scale bounds must not wrap
    set_min = 16'hFFF0; set_max = 16'hFFFF; ramp_enable = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    ramp_enable = 1'b0;
    @(negedge clk);

    // Random enables, backpressure, bounds and frame length
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      dac_ready = ($urandom_range(0, 9) < 7);
      dc_input  = 16'($urandom);
      if ($urandom_range(0, 29) == 0) ramp_enable = ~ramp_enable;
      if ($urandom_range(0, 29) == 0) dc_enable = ~dc_enable;
      if ($urandom_range(0, 49) == 0) read_length = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) begin
        int a, b;
        a = int'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, a));
        else begin
          b = a + int'($urandom_range(0, 24));
          if (b > 65535) b = 65535;
        end
        set_min = 16'(a); set_max = 16'(b);
      end
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ramp_dc_gen.md
# ramp_dc_gen

Waveform sample generator that sits directly downstream of the UART command decoder. It consumes the decoder's `ramp_enable`, `dc_enable`, `set_min`, `set_max` and `dc_input` outputs. It emits a paced stream of 16-bit DAC codes over a valid/ready handshake to the DAC driver: a triangle ramp between min and max, or a DC level. It also counts emitted samples against `read_length` for the read-back path.

## Interface
- `DATA_W`, 16, sample/code width
- `SAMPLE_DIV`, 100, clk cycles per sample tick (≥2)
- `STEP`, 1, ramp increment per sample (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ramp_enable`  in  1  level; run triangle ramp
- `dc_enable`  in  1  level; run DC output
- `set_min`  in  16  ramp lower bound
- `set_max`  in  16  ramp upper bound
- `dc_input`  in  16  DC level
- `read_length`  in  16  samples per frame; 0 = no frame counting
- `dac_ready`  in  1  downstream accepts sample
- `dac_code`  out  16  current sample
- `dac_valid`  out  1  sample pending
- `mode`  out  2  0 idle, 1 ramp, 2 dc
- `frame_done`  out  1  one-cycle pulse at end of frame
- `overrun`  out  1  sticky; a sample was overwritten before acceptance

## Operation
- FSM states: IDLE, RAMP, DC. `mode` mirrors the state.
- IDLE→RAMP when `ramp_enable` is high. IDLE→DC when `dc_enable` is high and `ramp_enable` is low. `ramp_enable` has priority.
- RAMP→IDLE when `ramp_enable` falls; RAMP→DC is not direct. DC→IDLE when `dc_enable` falls, or when `ramp_enable` rises (ramp priority).
- On RAMP entry:
  - latch `set_min`/`set_max` into `lo`/`hi`.
  - set `cur`=`lo`, direction up.
  - clear the tick divider, `sample_cnt` and the pending sample.
- Later input changes are ignored until the next entry.
- Ramp step on each tick, using 17-bit arithmetic so nothing wraps:
  - Up: if `cur`+STEP ≥ `hi` then `cur`=`hi` and direction becomes down; else `cur`+=STEP.
  - Down: if `cur` ≤ `lo`+STEP then `cur`=`lo` and direction becomes up; else `cur`-=STEP.
  - If `lo` ≥ `hi`, `cur` stays at `lo`.
- DC: each sample takes the live `dc_input`, not a latched copy.
- Sample emission:
  - On each tick, present the sample, i.e. `dac_code`=value and `dac_valid`=1.
  - The sample is consumed when `dac_valid`&&`dac_ready`, and `dac_valid` drops next cycle unless a tick coincides.
  - A tick while the previous sample is unconsumed overwrites it and sets `overrun`.
  - Acceptance and a new tick in the same cycle: the new sample wins, `dac_valid` stays 1, and `overrun` is not set.
- Frame counting:
  - `sample_cnt` increments on each accepted sample.
  - When `read_length`≠0 and the count reaches `read_length`, pulse `frame_done` and reset the count to 0. Generation continues.
  - `read_length` is compared live.
- `overrun` clears only on reset or on mode entry.
- Entering IDLE:
  - `dac_valid` drops next cycle; the pending sample is discarded.
  - `dac_code` holds its last value.
  - Counters freeze.

## Timing
- Reset values: `dac_code`=0, `dac_valid`=0, `mode`=0, `frame_done`=0, `overrun`=0. Internal `cur`, `lo`, `hi`, `sample_cnt`, divider and direction are all 0 / up.
- Enable seen high at edge N: `mode` updates at N+1, and the first sample (`lo` or `dc_input`) is valid at N+1.
- Subsequent ticks follow every SAMPLE_DIV cycles (N+1+k·SAMPLE_DIV).
- Enable falling at edge N: `mode`=0 and `dac_valid`=0 at N+1.
- `frame_done` asserts the cycle after the accepting handshake that completes the frame.
- Reset mid-operation forces every output to its reset value immediately, since reset is asynchronous.

## Structure
- Shared package holds: mode encodings (`MODE_IDLE`=0, `MODE_RAMP`=1, `MODE_DC`=2) and `DATA_W`.
- One sub-module, `sample_tick_div`: counter with clear, emits `tick` when the count is SAMPLE_DIV-1. Everything else lives in the top module.

## Test plan
- Ramp sweep, SAMPLE_DIV=4, STEP=1, min=2, max=5, ready=1:
  - codes are 2,3,4,5,4,3,2,3… at 4-cycle spacing.
  - `mode`=1; `overrun` stays 0.
- Non-divisible step, STEP=3, min=0, max=7: codes are 0,3,6,7,4,1,0,3.
- DC tracking, dc_enable with dc_input=0x1234, changed to 0xABCD mid-run: the next tick emits 0xABCD, `mode`=2.
- Backpressure: ready=0 for 2 ticks gives `overrun`=1 and `dac_code`=latest value. Setting ready=1 accepts one sample; `overrun` stays set until re-entry.
- Frames, read_length=3, ready=1: `frame_done` pulses after samples 3, 6, 9. With read_length=0, no pulses.
- Priority/reset:
  - both enables high → ramp mode.
  - drop ramp_enable → IDLE with `dac_code` held.
  - async rst mid-ramp → all outputs 0 immediately.
  - min=9, max=4 → constant 9.
